// File: rtl/ti_adc_os_cal_if.sv
// Signal bundle between the offset-calibration sequencer and its ADC/config side.
// The master drives the calibration requests and the samples; the slave is the sequencer.
interface ti_adc_os_cal_if #(
   parameter int ADC_WAYS   = 8,
   parameter int ADC_BITS   = 9,
   parameter int OSDAC_BITS = 8
);
   localparam int WAY_W = (ADC_WAYS > 1) ? $clog2(ADC_WAYS) : 1;

   logic                                 cal_start;
   logic                                 cal_abort;
   logic [ADC_WAYS-1:0]                  cal_mask;
   logic                                 sample_valid;
   logic [ADC_WAYS-1:0][ADC_BITS-1:0]    adc_data;
   logic                                 cfg_we;
   logic [WAY_W-1:0]                     cfg_way;
   logic [OSDAC_BITS-1:0]                cfg_code;
   logic [ADC_WAYS-1:0][OSDAC_BITS-1:0]  data_vosp;
   logic [ADC_WAYS-1:0][OSDAC_BITS-1:0]  data_vosn;
   logic                                 cal_busy;
   logic                                 cal_done;
   logic [WAY_W-1:0]                     cal_way;

   modport master (
      output cal_start, cal_abort, cal_mask, sample_valid, adc_data,
             cfg_we, cfg_way, cfg_code,
      input  data_vosp, data_vosn, cal_busy, cal_done, cal_way
   );

   modport slave (
      input  cal_start, cal_abort, cal_mask, sample_valid, adc_data,
             cfg_we, cfg_way, cfg_code,
      output data_vosp, data_vosn, cal_busy, cal_done, cal_way
   );
endinterface

// File: rtl/ti_adc_os_cal.sv
// Foreground offset-calibration sequencer: SAR-searches each enabled way's offset-DAC
// code so the averaged way output lands on mid-code, then holds the codes.
//
// state  | meaning
// IDLE   | waiting for cal_start; manual code writes accepted
// SEL    | pick lowest enabled way not yet done, save its code, load mid code
// SET    | trial code applied, arm settle/sample counters
// SETTLE | wait SETTLE_CYC cycles for the offset DAC to settle
// ACCUM  | accumulate 2^AVG_LOG2 valid samples of the selected way
// DECIDE | keep/clear the trial bit, step to next bit or next way
// DONE   | one-cycle completion pulse
module ti_adc_os_cal #(
   parameter int ADC_WAYS   = 8,
   parameter int ADC_BITS   = 9,
   parameter int OSDAC_BITS = 8,
   parameter int SETTLE_CYC = 4,
   parameter int AVG_LOG2   = 2,
   parameter int POL        = 0
) (
   input logic            clk,
   input logic            rstn,
   ti_adc_os_cal_if.slave bus
);
   localparam int WAY_W = (ADC_WAYS > 1) ? $clog2(ADC_WAYS) : 1;
   localparam int BIT_W = (OSDAC_BITS > 1) ? $clog2(OSDAC_BITS) : 1;
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int ACC_W = ADC_BITS + AVG_LOG2;

   localparam logic [ACC_W-1:0]      MID      = ACC_W'(2 ** (ADC_BITS - 1 + AVG_LOG2));
   localparam logic [OSDAC_BITS-1:0] CODE_RST = {1'b1, {(OSDAC_BITS-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE, SEL, SET, SETTLE, ACCUM, DECIDE, DONE
   } state_t;

   state_t state, state_nxt;

   logic [ADC_WAYS-1:0][OSDAC_BITS-1:0] code;
   logic [ADC_WAYS-1:0]                 mask_q;
   logic [ADC_WAYS-1:0]                 done_q;
   logic [WAY_W-1:0]                    cal_way_q;
   logic [BIT_W-1:0]                    bit_idx;
   logic [CNT_W-1:0]                    settle_cnt;
   logic [SMP_W-1:0]                    smp_cnt;
   logic [ACC_W-1:0]                    acc;
   logic [OSDAC_BITS-1:0]               old_code;
   logic                                in_prog;

   logic [ADC_WAYS-1:0]   pend;
   logic                  sel_found;
   logic [WAY_W-1:0]      sel_way;
   logic                  abort_hit;
   logic                  clr_bit;
   logic [OSDAC_BITS-1:0] trial_code;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      abort_hit = 1'b0;
      pend      = mask_q & ~done_q;
      sel_found = 1'b0;
      sel_way   = '0;
      for (int i = ADC_WAYS - 1; i >= 0; i--) begin
         if (pend[i]) begin
            sel_found = 1'b1;
            sel_way   = WAY_W'(i);
         end
      end

      clr_bit    = (POL != 0) ? (acc < MID) : (acc > MID);
      trial_code = code[cal_way_q];
      if (clr_bit) trial_code[bit_idx] = 1'b0;
      if (bit_idx != '0) trial_code[bit_idx - 1'b1] = 1'b1;

      case (state)
         IDLE:    if (bus.cal_start) state_nxt = SEL;
         SEL:     state_nxt = sel_found ? SET : DONE;
         SET:     state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == '0) state_nxt = ACCUM;
         ACCUM:   if (bus.sample_valid && smp_cnt == '0) state_nxt = DECIDE;
         DECIDE:  state_nxt = (bit_idx == '0) ? SEL : SET;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // DONE is already signalling completion, so an abort there has nothing to undo
      if (bus.cal_abort && state != IDLE && state != DONE) begin
         abort_hit = 1'b1;
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int w = 0; w < ADC_WAYS; w++) code[w] <= CODE_RST;
         mask_q     <= '0;
         done_q     <= '0;
         cal_way_q  <= '0;
         bit_idx    <= '0;
         settle_cnt <= '0;
         smp_cnt    <= '0;
         acc        <= '0;
         old_code   <= '0;
         in_prog    <= 1'b0;
      end else if (abort_hit) begin
         if (in_prog) code[cal_way_q] <= old_code;
         in_prog <= 1'b0;
         acc     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cfg_we) code[bus.cfg_way] <= bus.cfg_code;
               if (bus.cal_start) begin
                  mask_q <= bus.cal_mask;
                  done_q <= '0;
               end
            end
            SEL: begin
               acc <= '0;
               if (sel_found) begin
                  cal_way_q     <= sel_way;
                  old_code      <= code[sel_way];
                  code[sel_way] <= CODE_RST;
                  bit_idx       <= BIT_W'(OSDAC_BITS - 1);
                  in_prog       <= 1'b1;
               end
            end
            SET: begin
               settle_cnt <= CNT_W'(SETTLE_CYC - 1);
               smp_cnt    <= SMP_W'(2 ** AVG_LOG2 - 1);
            end
            SETTLE: begin
               if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            end
            ACCUM: begin
               if (bus.sample_valid) begin
                  acc <= acc + ACC_W'(bus.adc_data[cal_way_q]);
                  if (smp_cnt != '0) smp_cnt <= smp_cnt - 1'b1;
               end
            end
            DECIDE: begin
               code[cal_way_q] <= trial_code;
               acc             <= '0;
               if (bit_idx == '0) begin
                  done_q[cal_way_q] <= 1'b1;
                  in_prog           <= 1'b0;
               end else begin
                  bit_idx <= bit_idx - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.data_vosp = code;
   assign bus.data_vosn = ~code;
   assign bus.cal_busy  = (state != IDLE);
   assign bus.cal_done  = (state == DONE);
   assign bus.cal_way   = cal_way_q;
endmodule

// File: tb/tb_ti_adc_os_cal.sv
// Directed bench for ti_adc_os_cal: an ADC model closes the loop through the codes,
// and expected per-way codes are queued at stimulus time and popped after each run.
module tb_ti_adc_os_cal;
   localparam int WAYS = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   ti_adc_os_cal_if #(.ADC_WAYS(WAYS), .ADC_BITS(9), .OSDAC_BITS(8)) bus ();

   ti_adc_os_cal #(
      .ADC_WAYS(WAYS), .ADC_BITS(9), .OSDAC_BITS(8),
      .SETTLE_CYC(4), .AVG_LOG2(2), .POL(0)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int t_cur   [WAYS];
   int model_c [WAYS];

   // Shorted-input ADC: output rises with the code and crosses mid-code at c = T
   always_comb begin
      for (int w = 0; w < WAYS; w++)
         bus.adc_data[w] = 9'(256 + int'(bus.data_vosp[w]) - t_cur[w]);
   end

   typedef struct {int way; int exp;} sb_t;
   sb_t sb_q[$];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_codes(input logic [7:0] m);
      for (int w = 0; w < WAYS; w++) begin
         sb_t e;
         if (m[w]) model_c[w] = t_cur[w];
         e.way = w;
         e.exp = model_c[w];
         sb_q.push_back(e);
      end
   endtask

   task automatic pop_codes(input string tag);
      while (sb_q.size() > 0) begin
         sb_t e;
         e = sb_q.pop_front();
         check($sformatf("%s_vosp%0d", tag, e.way), int'(bus.data_vosp[e.way]), e.exp);
         check($sformatf("%s_vosn%0d", tag, e.way), int'(bus.data_vosn[e.way]), 255 - e.exp);
      end
   endtask

   task automatic run_cal(input logic [7:0] m, input bit rnd, input int exp_busy, input string tag);
      int busy_cnt;
      bit seen;
      busy_cnt = 0;
      seen     = 1'b0;
      bus.cal_mask  = m;
      bus.cal_start = 1'b1;
      tick();
      bus.cal_start = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (bus.cal_done) begin
            seen = 1'b1;
            check({tag, "_busy_at_done"}, int'(bus.cal_busy), 1);
         end else if (bus.cal_busy) begin
            busy_cnt++;
         end
         if (rnd) bus.sample_valid = 1'($urandom_range(0, 1));
         tick();
         if (seen) break;
      end
      bus.sample_valid = 1'b1;
      check({tag, "_done_seen"}, int'(seen), 1);
      if (exp_busy >= 0) check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
      check({tag, "_busy_after"}, int'(bus.cal_busy), 0);
      check({tag, "_done_single"}, int'(bus.cal_done), 0);
   endtask

   initial begin
      bit done_during;
      bit reached;

      bus.cal_start    = 1'b0;
      bus.cal_abort    = 1'b0;
      bus.cal_mask     = '0;
      bus.sample_valid = 1'b1;
      bus.cfg_we       = 1'b0;
      bus.cfg_way      = '0;
      bus.cfg_code     = '0;
      for (int w = 0; w < WAYS; w++) begin
         t_cur[w]   = 128;
         model_c[w] = 128;
      end
      tick(); tick();
      rstn = 1'b1;
      tick();

      // 1: reset state
      push_codes(8'h00);
      pop_codes("rst");
      check("rst_busy", int'(bus.cal_busy), 0);
      check("rst_done", int'(bus.cal_done), 0);
      check("rst_way",  int'(bus.cal_way),  0);

      // empty mask: SEL then DONE
      run_cal(8'h00, 1'b0, 1, "mask0");
      push_codes(8'h00);
      pop_codes("mask0");

      // 2: all ways
      t_cur = '{10, 200, 128, 0, 255, 77, 129, 1};
      push_codes(8'hFF);
      run_cal(8'hFF, 1'b0, 8 * 81 + 1, "all");
      pop_codes("all");

      // 3: ways 0 and 2 only
      t_cur = '{50, 60, 70, 80, 90, 100, 110, 120};
      push_codes(8'h05);
      run_cal(8'h05, 1'b0, 2 * 81 + 1, "m05");
      pop_codes("m05");

      // 4: abort while way 3 is in progress
      t_cur = '{3, 33, 66, 99, 150, 180, 210, 240};
      push_codes(8'h07);
      done_during = 1'b0;
      reached     = 1'b0;
      bus.cal_mask  = 8'hFF;
      bus.cal_start = 1'b1;
      tick();
      bus.cal_start = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (bus.cal_done) done_during = 1'b1;
         if (bus.cal_busy && bus.cal_way == 3'd3) begin
            reached = 1'b1;
            break;
         end
         tick();
      end
      check("abort_reach_way3", int'(reached), 1);
      for (int k = 0; k < 25; k++) begin
         if (bus.cal_done) done_during = 1'b1;
         tick();
      end
      bus.cal_abort = 1'b1;
      tick();
      bus.cal_abort = 1'b0;
      check("abort_busy", int'(bus.cal_busy), 0);
      check("abort_done", int'(bus.cal_done | done_during), 0);
      pop_codes("abort");

      // 5: ragged sample_valid gives the same codes as run 2
      t_cur = '{10, 200, 128, 0, 255, 77, 129, 1};
      push_codes(8'hFF);
      run_cal(8'hFF, 1'b1, -1, "rnd");
      pop_codes("rnd");

      // 6: manual write when idle, ignored write and start while busy
      bus.cfg_we   = 1'b1;
      bus.cfg_way  = 3'd5;
      bus.cfg_code = 8'h3C;
      tick();
      bus.cfg_we = 1'b0;
      model_c[5] = 8'h3C;
      push_codes(8'h00);
      pop_codes("cfg");

      push_codes(8'h01);
      done_during = 1'b0;
      bus.cal_mask  = 8'h01;
      bus.cal_start = 1'b1;
      tick();
      bus.cal_start = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      bus.cfg_we    = 1'b1;
      bus.cfg_way   = 3'd5;
      bus.cfg_code  = 8'h11;
      bus.cal_start = 1'b1;
      tick();
      bus.cfg_we    = 1'b0;
      bus.cal_start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (bus.cal_done) done_during = 1'b1;
         tick();
      end
      check("busy_ignore_done", int'(done_during), 1);
      check("busy_ignore_idle", int'(bus.cal_busy), 0);
      pop_codes("busy_ignore");

      // cfg write, start and abort together in idle: write lands, start wins
      bus.cfg_we    = 1'b1;
      bus.cfg_way   = 3'd0;
      bus.cfg_code  = 8'h55;
      bus.cal_mask  = 8'h01;
      bus.cal_start = 1'b1;
      bus.cal_abort = 1'b1;
      tick();
      bus.cfg_we    = 1'b0;
      bus.cal_start = 1'b0;
      bus.cal_abort = 1'b0;
      check("start_wins_busy", int'(bus.cal_busy), 1);
      tick(); tick();
      check("start_mid_code", int'(bus.data_vosp[0]), 128);
      bus.cal_abort = 1'b1;
      tick();
      bus.cal_abort = 1'b0;
      model_c[0] = 8'h55;
      push_codes(8'h00);
      pop_codes("wr_then_start");

      // asynchronous reset mid-run
      bus.cal_mask  = 8'hFF;
      bus.cal_start = 1'b1;
      tick();
      bus.cal_start = 1'b0;
      for (int k = 0; k < 100; k++) tick();
      #2 rstn = 1'b0;
      #1;
      for (int w = 0; w < WAYS; w++) model_c[w] = 128;
      push_codes(8'h00);
      pop_codes("async_rst");
      check("async_rst_busy", int'(bus.cal_busy), 0);
      check("async_rst_way",  int'(bus.cal_way),  0);
      tick();
      rstn = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
